// File: rtl/ddr_cmd_responder.sv
// ddr_cmd_responder: DDR4 command decoder with per-bank state/timing checks and CL/CWL data strobes.
module ddr_cmd_responder #(
  parameter int NUMBER_BANK = 16,
  parameter int RA_WIDTH    = 15,
  parameter int tRCD        = 14,
  parameter int tRP         = 14,
  parameter int tRAS        = 32,
  parameter int tRTP        = 8,
  parameter int CL          = 14,
  parameter int CWL         = 12
) (
  input  logic                   clock_t,
  input  logic                   reset_n,
  input  logic                   cs_n,
  input  logic                   act_n,
  input  logic                   ras_n,
  input  logic                   cas_n,
  input  logic                   we_n,
  input  logic [1:0]             bg_addr,
  input  logic [1:0]             ba_addr,
  input  logic [RA_WIDTH-1:0]    addr,
  output logic                   cmd_valid,
  output logic [2:0]             cmd_type,
  output logic [NUMBER_BANK-1:0] bank_open,
  output logic [RA_WIDTH-1:0]    open_row,
  output logic                   rd_data_en,
  output logic                   wr_data_en,
  output logic                   err_valid,
  output logic [2:0]             err_code
);
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, PRECHARGING} bank_state_e;
  localparam logic [5:0] SAT    = 6'd63;
  localparam logic [5:0] RCD_M1 = 6'(tRCD - 1);
  localparam logic [5:0] RP_M1  = 6'(tRP - 1);
  localparam logic [5:0] RAS_C  = 6'(tRAS);
  localparam logic [5:0] RTP_C  = 6'(tRTP);
  bank_state_e         state_q [NUMBER_BANK];
  bank_state_e         state_d [NUMBER_BANK];
  logic [5:0]          act_cnt_q [NUMBER_BANK];
  logic [5:0]          act_cnt_d [NUMBER_BANK];
  logic [5:0]          pre_cnt_q [NUMBER_BANK];
  logic [5:0]          pre_cnt_d [NUMBER_BANK];
  logic [5:0]          rd_cnt_q  [NUMBER_BANK];
  logic [5:0]          rd_cnt_d  [NUMBER_BANK];
  logic [RA_WIDTH-1:0] row_q [NUMBER_BANK];
  logic [RA_WIDTH-1:0] row_d [NUMBER_BANK];
  logic                cmd_valid_q, cmd_valid_d, err_valid_q, err_valid_d;
  logic [2:0]          cmd_type_q, cmd_type_d, err_code_q, err_code_d, err, e_pre;
  logic [RA_WIDTH-1:0] open_row_q, open_row_d;
  logic [CL:0]         rd_pipe_q, rd_pipe_d;
  logic [CWL:0]        wr_pipe_q, wr_pipe_d;
  logic                is_act, is_pre, is_prea, is_pre_one, is_rd, is_wr, rd_acc, wr_acc;
  logic [3:0]          bank;
  assign bank       = {bg_addr, ba_addr};
  assign is_act     = !cs_n && !act_n;
  assign is_pre     = !cs_n && act_n && !ras_n && cas_n && !we_n;
  assign is_rd      = !cs_n && act_n && ras_n && !cas_n && we_n;
  assign is_wr      = !cs_n && act_n && ras_n && !cas_n && !we_n;
  assign is_prea    = is_pre && addr[10];
  assign is_pre_one = is_pre && !addr[10];
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rd_acc      = 1'b0;
    wr_acc      = 1'b0;
    err         = 3'd0;
    e_pre       = 3'd0;
    act_cnt_d   = act_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    for (int b = 0; b < NUMBER_BANK; b++) begin
      act_cnt_d[b] = act_cnt_q[b] == SAT ? SAT : act_cnt_q[b] + 6'd1;
      pre_cnt_d[b] = pre_cnt_q[b] == SAT ? SAT : pre_cnt_q[b] + 6'd1;
      rd_cnt_d[b]  = rd_cnt_q[b]  == SAT ? SAT : rd_cnt_q[b]  + 6'd1;
      // State reflects the counter value it will hold after this edge
      if (state_q[b] == OPENING && act_cnt_q[b] >= RCD_M1) state_d[b] = OPEN;
      if (state_q[b] == PRECHARGING && pre_cnt_q[b] >= RP_M1) state_d[b] = CLOSED;
      if ((is_prea || (is_pre_one && 4'(b) == bank)) && state_q[b] != CLOSED) begin
        e_pre = act_cnt_q[b] < RAS_C ? 3'd5 : rd_cnt_q[b] < RTP_C ? 3'd6 : 3'd0;
        if (e_pre != 3'd0 && (err == 3'd0 || e_pre < err)) err = e_pre;
        state_d[b]   = PRECHARGING;
        pre_cnt_d[b] = 6'd0;
      end
    end
    if (is_act) begin
      if (state_q[bank] == OPENING || state_q[bank] == OPEN) err = 3'd1;
      else begin
        err              = state_q[bank] == PRECHARGING ? 3'd4 : 3'd0;
        state_d[bank]    = OPENING;
        row_d[bank]      = addr;
        act_cnt_d[bank]  = 6'd0;
      end
    end
    if (is_rd || is_wr) begin
      if (state_q[bank] == CLOSED || state_q[bank] == PRECHARGING) err = 3'd2;
      else begin
        err    = state_q[bank] == OPENING ? 3'd3 : 3'd0;
        rd_acc = is_rd;
        wr_acc = is_wr;
        if (is_rd) rd_cnt_d[bank] = 6'd0;
      end
    end
    cmd_valid_d = is_act || is_pre || is_rd || is_wr;
    cmd_type_d  = is_act ? 3'd1 : is_prea ? 3'd3 : is_pre ? 3'd2 : is_rd ? 3'd4 : is_wr ? 3'd5 : 3'd0;
    open_row_d  = cmd_valid_d ? row_d[bank] : open_row_q;
    err_valid_d = err != 3'd0;
    err_code_d  = err;
    rd_pipe_d   = {rd_pipe_q[CL-1:0], rd_acc};
    wr_pipe_d   = {wr_pipe_q[CWL-1:0], wr_acc};
  end
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= '{default: CLOSED};
      act_cnt_q   <= '{default: SAT};
      pre_cnt_q   <= '{default: SAT};
      rd_cnt_q    <= '{default: SAT};
      row_q       <= '{default: '0};
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 3'd0;
      open_row_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 3'd0;
      rd_pipe_q   <= '0;
      wr_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      act_cnt_q   <= act_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      row_q       <= row_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      open_row_q  <= open_row_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      rd_pipe_q   <= rd_pipe_d;
      wr_pipe_q   <= wr_pipe_d;
    end
  end
  always_comb begin
    bank_open = '0;
    for (int b = 0; b < NUMBER_BANK; b++) bank_open[b] = state_q[b] == OPENING || state_q[b] == OPEN;
  end
  assign cmd_valid  = cmd_valid_q;
  assign cmd_type   = cmd_type_q;
  assign open_row   = open_row_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign rd_data_en = rd_pipe_q[CL];
  assign wr_data_en = wr_pipe_q[CWL];
endmodule

// File: tb/tb_ddr_cmd_responder.sv
// tb_ddr_cmd_responder: directed command sequences with hand-computed responses.
module tb_ddr_cmd_responder;
  logic        clock_t = 1'b0, reset_n = 1'b0;
  logic        cs_n = 1'b1, act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  bg_addr = 2'd0, ba_addr = 2'd0;
  logic [14:0] addr = 15'd0;
  logic        cmd_valid, rd_data_en, wr_data_en, err_valid;
  logic [2:0]  cmd_type, err_code;
  logic [15:0] bank_open;
  logic [14:0] open_row;
  int          n_chk = 0, n_fail = 0;

  ddr_cmd_responder dut (
    .clock_t(clock_t), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .bg_addr(bg_addr), .ba_addr(ba_addr), .addr(addr),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .bank_open(bank_open), .open_row(open_row),
    .rd_data_en(rd_data_en), .wr_data_en(wr_data_en), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clock_t = ~clock_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic deselect();
    cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    bg_addr = 2'd0; ba_addr = 2'd0; addr = 15'd0;
  endtask

  // k: 1 ACT, 2 PRE, 3 PREA, 4 RD, 5 WR; returns at the negedge after the command edge
  task automatic issue(input int k, input int b, input int row);
    cs_n = 1'b0;
    act_n = (k != 1);
    ras_n = !(k == 2 || k == 3);
    cas_n = !(k == 4 || k == 5);
    we_n  = !(k == 2 || k == 3 || k == 5);
    {bg_addr, ba_addr} = 4'(b);
    addr = (k == 3) ? 15'h400 : 15'(row);
    @(negedge clock_t);
    deselect();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_t);
  endtask

  task automatic check_cmd(input string tag, input int typ, input int ev, input int ec);
    chk({tag, "_valid"}, cmd_valid, 1);
    chk({tag, "_type"}, cmd_type, typ);
    chk({tag, "_errv"}, err_valid, ev);
    chk({tag, "_errc"}, err_code, ec);
  endtask

  initial begin
    deselect();
    idle(2);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_type", cmd_type, 0);
    chk("rst_open", bank_open, 0);
    chk("rst_row", open_row, 0);
    chk("rst_rden", rd_data_en, 0);
    chk("rst_wren", wr_data_en, 0);
    chk("rst_errv", err_valid, 0);
    chk("rst_errc", err_code, 0);
    reset_n = 1'b1;
    idle(1);

    // Illegal format: ras/cas/we all low with act_n high
    cs_n = 1'b0; ras_n = 1'b0; cas_n = 1'b0; we_n = 1'b0;
    idle(1);
    deselect();
    chk("bad_valid", cmd_valid, 0);
    chk("bad_type", cmd_type, 0);

    issue(1, 5, 'h1A3);
    check_cmd("t1_act", 1, 0, 0);
    chk("t1_open5", bank_open[5], 1);
    chk("t1_row", open_row, 'h1A3);
    idle(14);
    issue(4, 5, 0);
    check_cmd("t1_rd", 4, 0, 0);
    chk("t1_rdrow", open_row, 'h1A3);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock_t);
      chk($sformatf("t1_rden_%0d", i), rd_data_en, (i == 14));
    end

    issue(1, 2, 'h55);
    check_cmd("t2_act", 1, 0, 0);
    idle(9);
    issue(4, 2, 0);
    check_cmd("t2_rd", 4, 1, 3);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock_t);
      chk($sformatf("t2_rden_%0d", i), rd_data_en, (i == 14));
    end

    issue(1, 0, 'h12);
    check_cmd("t3_act", 1, 0, 0);
    idle(19);
    issue(2, 0, 0);
    check_cmd("t3_pre", 2, 1, 5);
    chk("t3_open0", bank_open[0], 0);
    idle(7);
    issue(1, 0, 'h34);
    check_cmd("t3_act2", 1, 1, 4);
    chk("t3_reopen0", bank_open[0], 1);
    chk("t3_row", open_row, 'h34);

    issue(1, 3, 7);
    check_cmd("t4_act", 1, 0, 0);
    idle(39);
    issue(1, 3, 9);
    check_cmd("t4_act2", 1, 1, 1);
    chk("t4_row", open_row, 7);
    chk("t4_open3", bank_open[3], 1);

    issue(1, 1, 'h11);
    issue(1, 4, 'h44);
    issue(1, 9, 'h99);
    chk("t5_opened", bank_open, 16'h023F);
    idle(40);
    issue(3, 0, 0);
    check_cmd("t5_prea", 3, 0, 0);
    chk("t5_allclosed", bank_open, 0);
    issue(5, 4, 0);
    check_cmd("t5_wr", 5, 1, 2);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock_t);
      chk($sformatf("t5_wren_%0d", i), wr_data_en, 0);
    end

    issue(1, 6, 'h66);
    idle(14);
    issue(4, 6, 0);
    check_cmd("t6_rd", 4, 0, 0);
    idle(5);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_open", bank_open, 0);
    chk("t6_rst_valid", cmd_valid, 0);
    @(negedge clock_t);
    reset_n = 1'b1;
    issue(1, 6, 'h67);
    check_cmd("t6_act", 1, 0, 0);
    chk("t6_open6", bank_open, 16'h0040);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock_t);
      chk($sformatf("t6_rden_%0d", i), rd_data_en, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_responder.md
Name: ddr_cmd_responder

Overview:
- Memory-side receiver for the DDR4 command bus driven by the controller's ACT/PRE/CAS sequencers.
- Decodes ACT, PRE, PREA, RD and WR on each clock, and tracks per-bank open/closed state and open row.
- Checks tRCD, tRP, tRAS and tRTP, and flags protocol or timing errors.
- Generates read/write data-enable strobes at CL/CWL latency for the memory model data path.

Parameters:
- NUMBER_BANK, 16, bank count; bank index = {bg_addr, ba_addr}.
- RA_WIDTH, 15, row address width.
- tRCD, 14, minimum cycles from ACT to RD/WR on the same bank.
- tRP, 14, minimum cycles from PRE to ACT on the same bank.
- tRAS, 32, minimum cycles from ACT to PRE on the same bank.
- tRTP, 8, minimum cycles from RD to PRE on the same bank.
- CL, 14, read latency: RD to rd_data_en.
- CWL, 12, write latency: WR to wr_data_en.

Ports:
- clock_t  in  1  main clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select; high means deselect (no command).
- act_n  in  1  low with cs_n low means ACT.
- ras_n, cas_n, we_n  in  1 each  command code when act_n is high.
- bg_addr  in  2  bank group.
- ba_addr  in  2  bank address.
- addr  in  RA_WIDTH  row address on ACT; bit 10 selects PREA on a PRE command.
- cmd_valid  out  1  one-cycle pulse: a legal-format command was decoded.
- cmd_type  out  3  0 NOP, 1 ACT, 2 PRE, 3 PREA, 4 RD, 5 WR.
- bank_open  out  NUMBER_BANK  1 = bank holds an open row.
- open_row  out  RA_WIDTH  open row of the addressed bank, registered with cmd_valid.
- rd_data_en  out  1  pulse CL cycles after an accepted RD.
- wr_data_en  out  1  pulse CWL cycles after an accepted WR.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  error code; see Behaviour.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - All banks go to CLOSED.
  - All outputs are 0.
  - Latency pipes are flushed; strobes in flight are dropped.
  - Per-bank counters saturate at max, so the first command after reset has no timing violation.
- Decode, registered, outputs 1 cycle after the command edge:
  - cs_n=1 → NOP, cmd_valid=0.
  - act_n=0 → ACT.
  - ras/cas/we: L,H,L → PRE (addr[10]=1 → PREA); H,L,H → RD; H,L,L → WR.
  - Any other combination → NOP with cmd_valid=0.
- Per-bank FSM: CLOSED → (ACT) → OPENING → (tRCD elapsed) → OPEN → (PRE) → PRECHARGING → (tRP elapsed) → CLOSED.
- Per-bank counters: cyc_since_act, cyc_since_pre and cyc_since_rd. Each is reset to 0 on its command, increments every cycle and saturates at 63.
- ACT:
  - Bank OPENING or OPEN → err 1 (ACT to open bank); bank state and row are unchanged.
  - Bank PRECHARGING with cyc_since_pre < tRP → err 4; the ACT is still applied.
  - Otherwise, or after err 4: store the row, state becomes OPENING, bank_open bit set.
- RD/WR:
  - Bank CLOSED or PRECHARGING → err 2; no data strobe is issued.
  - Bank OPENING (cyc_since_act < tRCD) → err 3; the access is still applied and its strobe is issued.
- PRE:
  - Bank CLOSED → legal NOP, no error.
  - cyc_since_act < tRAS → err 5.
  - Else cyc_since_rd < tRTP → err 6.
  - The PRE is applied in all non-CLOSED cases; bank_open bit is cleared in the same cycle as cmd_valid.
- PREA: applies PRE to every non-CLOSED bank. One err pulse is reported, with the lowest code found across banks.
- Error priority on a single command: lowest code wins; one err pulse per command at most.
- Latency pipes:
  - rd_data_en and wr_data_en come from shift registers of depth CL and CWL.
  - Back-to-back accepted commands give back-to-back strobes; there is no overlap suppression.
- Deselect cycles still advance all counters and pipes.

Test Plan:
- ACT bank 5 row 0x1A3, idle 14 cycles, RD bank 5 → cmd_type 1 then 4, bank_open[5]=1, open_row=0x1A3, rd_data_en high exactly 14 cycles after the RD cmd_valid, no err.
- ACT bank 2, RD bank 2 after 10 cycles → err_code 3; rd_data_en still pulses CL cycles later.
- ACT bank 0, PRE bank 0 after 20 cycles → err_code 5, bank_open[0]=0; ACT bank 0 8 cycles later → err_code 4.
- ACT bank 3 row 7, second ACT bank 3 row 9 after 40 cycles → err_code 1; open_row stays 7.
- ACT banks 1, 4, 9; wait 40 cycles; PREA → cmd_type 3, bank_open=0, no err; WR bank 4 → err_code 2, no wr_data_en.
- RD bank 6 in flight, reset_n pulsed low mid-latency → rd_data_en never asserts, bank_open=0; after reset, ACT bank 6 with no wait → no err.
